// File: rtl/matrix_row_server_pkg.sv
// Shared types for the matrix row server: default geometry, packed complex
// element/row types, address type, dump FSM states and an element selector.
package mat_pkg;

  localparam int MAT_SIZE  = 4;
  localparam int MAT_WIDTH = 64;
  localparam int MAT_AW    = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;

  typedef logic [MAT_WIDTH-1:0] part_t;

  // Imaginary part in the high half, real part in the low half.
  typedef struct packed {
    part_t im;
    part_t re;
  } cplx_t;

  // Element j sits at bits [j*2*WIDTH +: 2*WIDTH].
  typedef cplx_t [MAT_SIZE-1:0] row_t;
  typedef logic [MAT_AW-1:0]    addr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } dump_state_e;

  function automatic cplx_t elem_sel(input row_t row, input int unsigned j);
    return row[j];
  endfunction

endpackage

// File: rtl/matrix_row_server_if.sv
// Bundle of engine read/write, host load, dump stream and flush signals.
// master = engines/host/dump consumer side, slave = the row server.
interface matrix_row_server_if
  import mat_pkg::*;
#(
  parameter int SIZE  = MAT_SIZE,
  parameter int WIDTH = MAT_WIDTH
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int RW = SIZE * 2 * WIDTH;

  logic          flush_i;

  logic [AW-1:0] rd_addr_i;
  logic          rd_addr_valid_i;
  logic [RW-1:0] rd_row_o;
  logic [AW-1:0] rd_addr_o;
  logic          rd_valid_o;

  logic [RW-1:0] wr_row_i;
  logic [AW-1:0] wr_addr_i;
  logic          wr_valid_i;

  logic [RW-1:0] host_wr_row_i;
  logic [AW-1:0] host_wr_addr_i;
  logic          host_wr_valid_i;
  logic          host_wr_ready_o;

  logic          dump_start_i;
  logic          dump_transpose_i;
  logic [RW-1:0] dump_row_o;
  logic [AW-1:0] dump_addr_o;
  logic          dump_valid_o;
  logic          dump_ready_i;
  logic          busy_o;

  modport master (
    output flush_i,
    output rd_addr_i, rd_addr_valid_i,
    input  rd_row_o, rd_addr_o, rd_valid_o,
    output wr_row_i, wr_addr_i, wr_valid_i,
    output host_wr_row_i, host_wr_addr_i, host_wr_valid_i,
    input  host_wr_ready_o,
    output dump_start_i, dump_transpose_i, dump_ready_i,
    input  dump_row_o, dump_addr_o, dump_valid_o, busy_o
  );

  modport slave (
    input  flush_i,
    input  rd_addr_i, rd_addr_valid_i,
    output rd_row_o, rd_addr_o, rd_valid_o,
    input  wr_row_i, wr_addr_i, wr_valid_i,
    input  host_wr_row_i, host_wr_addr_i, host_wr_valid_i,
    output host_wr_ready_o,
    input  dump_start_i, dump_transpose_i, dump_ready_i,
    output dump_row_o, dump_addr_o, dump_valid_o, busy_o
  );

endinterface

// File: rtl/matrix_row_server_row_transpose.sv
// Combinational column gather: element j of the output is element `col` of
// row j, so a matrix column is presented as a row.
module row_transpose #(
  parameter int SIZE  = 4,
  parameter int WIDTH = 64,
  parameter int AW    = (SIZE > 1) ? $clog2(SIZE) : 1,
  parameter int RW    = SIZE * 2 * WIDTH
) (
  input  logic [SIZE-1:0][RW-1:0] rows,
  input  logic [AW-1:0]           col,
  output logic [RW-1:0]           col_row
);

  localparam int EW = 2 * WIDTH;

  // Gather element `col` from every row; an out-of-range column yields 0.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    col_row = '0;
    for (int j = 0; j < SIZE; j++) begin
      for (int k = 0; k < SIZE; k++) begin
        if (col == AW'(k)) begin
          col_row[j*EW +: EW] = rows[j][k*EW +: EW];
        end
      end
    end
  end

endmodule

// File: rtl/matrix_row_server.sv
// Row-organised storage for one SIZE x SIZE complex matrix. Serves engine
// row reads with one-cycle registered latency (write-first forwarding),
// absorbs engine and host row writes, and streams the matrix out as rows
// or, in transpose mode, as columns.
module matrix_row_server
  import mat_pkg::*;
#(
  parameter int SIZE  = MAT_SIZE,
  parameter int WIDTH = MAT_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  matrix_row_server_if.slave bus
);

  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int RW = SIZE * 2 * WIDTH;

  logic [SIZE-1:0][RW-1:0] mem;

  logic          host_ready;
  logic [RW-1:0] rd_data;

  logic          rd_valid_q;
  logic [AW-1:0] rd_addr_q;
  logic [RW-1:0] rd_row_q;

  dump_state_e   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          transpose_q, transpose_d;
  logic [RW-1:0] plain_row;
  logic [RW-1:0] col_row;
  logic          dumping;

  // Host load yields to an engine write to the same row; different rows
  // both commit in the same cycle.
  assign host_ready = rst_ni & bus.host_wr_valid_i &
                      ~(bus.wr_valid_i & (bus.wr_addr_i == bus.host_wr_addr_i));
  assign bus.host_wr_ready_o = host_ready;

  // Row storage: engine write has priority, out-of-range addresses hit no row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the row array is real state that must read back as zero after
      // reset, so it is cleared here rather than left uninitialised.
      mem <= '0;
    end else begin
      for (int r = 0; r < SIZE; r++) begin
        // NOTE: non-blocking updates keep every row's next value computed from
        // this cycle's state, independent of statement order.
        if (bus.wr_valid_i && (bus.wr_addr_i == AW'(r))) begin
          mem[r] <= bus.wr_row_i;
        end else if (host_ready && (bus.host_wr_addr_i == AW'(r))) begin
          mem[r] <= bus.host_wr_row_i;
        end
      end
    end
  end

  // Read data select with write-first forwarding of same-cycle writes.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < SIZE; r++) begin
      if (bus.rd_addr_i == AW'(r)) begin
        rd_data = mem[r];
        if (host_ready && (bus.host_wr_addr_i == AW'(r))) begin
          rd_data = bus.host_wr_row_i;
        end
        if (bus.wr_valid_i && (bus.wr_addr_i == AW'(r))) begin
          rd_data = bus.wr_row_i;
        end
      end
    end
  end

  // Registered read response; flush drops the response for this request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_row_q   <= '0;
    end else begin
      rd_valid_q <= bus.rd_addr_valid_i & ~bus.flush_i;
      if (bus.rd_addr_valid_i) begin
        rd_addr_q <= bus.rd_addr_i;
        rd_row_q  <= rd_data;
      end
    end
  end

  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_addr_o  = rd_addr_q;
  assign bus.rd_row_o   = rd_row_q;

  // Dump FSM state, beat index and latched transpose mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      transpose_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      transpose_q <= transpose_d;
    end
  end

  // Dump next-state: flush wins, start only in IDLE, last beat ends the dump.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    transpose_d = transpose_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.flush_i && bus.dump_start_i) begin
          state_d     = ST_DUMP;
          idx_d       = '0;
          transpose_d = bus.dump_transpose_i;
        end
      end
      ST_DUMP: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else if (bus.dump_ready_i) begin
          if (int'(idx_q) == SIZE - 1) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Plain-mode row select straight from current storage.
  always_comb begin
    plain_row = '0;
    for (int r = 0; r < SIZE; r++) begin
      if (idx_q == AW'(r)) begin
        plain_row = mem[r];
      end
    end
  end

  row_transpose #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_row_transpose (
    .rows    (mem),
    .col     (idx_q),
    .col_row (col_row)
  );

  assign dumping          = (state_q == ST_DUMP);
  assign bus.busy_o       = dumping;
  assign bus.dump_valid_o = dumping;
  assign bus.dump_addr_o  = dumping ? idx_q : '0;
  assign bus.dump_row_o   = dumping ? (transpose_q ? col_row : plain_row) : '0;

endmodule

// File: tb/tb_matrix_row_server.sv
// Directed self-checking bench for matrix_row_server (SIZE=4, WIDTH=64).
module tb_matrix_row_server;
  import mat_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   failures;

  row_t mdl [4];

  matrix_row_server_if #(.SIZE(4), .WIDTH(64)) bus ();

  matrix_row_server #(.SIZE(4), .WIDTH(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic row_t pattern_row(input int i);
    row_t r;
    for (int j = 0; j < 4; j++) begin
      r[j].re = $realtobits(real'(i * 4 + j));
      r[j].im = $realtobits(-real'(i * 4 + j));
    end
    return r;
  endfunction

  function automatic row_t const_row(input real re, input real im);
    row_t r;
    for (int j = 0; j < 4; j++) begin
      r[j].re = $realtobits(re);
      r[j].im = $realtobits(im);
    end
    return r;
  endfunction

  function automatic row_t col_of(input int c);
    row_t r;
    for (int j = 0; j < 4; j++) r[j] = mdl[j][c];
    return r;
  endfunction

  task automatic idle_inputs();
    bus.flush_i          = 1'b0;
    bus.rd_addr_i        = '0;
    bus.rd_addr_valid_i  = 1'b0;
    bus.wr_row_i         = '0;
    bus.wr_addr_i        = '0;
    bus.wr_valid_i       = 1'b0;
    bus.host_wr_row_i    = '0;
    bus.host_wr_addr_i   = '0;
    bus.host_wr_valid_i  = 1'b0;
    bus.dump_start_i     = 1'b0;
    bus.dump_transpose_i = 1'b0;
    bus.dump_ready_i     = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (bus.rd_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid_o); end
    tests++; if (bus.rd_addr_o !== '0) begin failures++; $display("FAIL reset_rd_addr got %0d want 0", bus.rd_addr_o); end
    tests++; if (bus.rd_row_o !== '0) begin failures++; $display("FAIL reset_rd_row got %h want 0", bus.rd_row_o); end
    tests++; if (bus.host_wr_ready_o !== 1'b0) begin failures++; $display("FAIL reset_host_ready got %b want 0", bus.host_wr_ready_o); end
    tests++; if (bus.dump_valid_o !== 1'b0) begin failures++; $display("FAIL reset_dump_valid got %b want 0", bus.dump_valid_o); end
    tests++; if (bus.dump_addr_o !== '0) begin failures++; $display("FAIL reset_dump_addr got %0d want 0", bus.dump_addr_o); end
    tests++; if (bus.dump_row_o !== '0) begin failures++; $display("FAIL reset_dump_row got %h want 0", bus.dump_row_o); end
    tests++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
  endtask

  task automatic test_host_load();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.host_wr_valid_i = 1'b1;
      bus.host_wr_addr_i  = 2'(i);
      bus.host_wr_row_i   = pattern_row(i);
      mdl[i]              = pattern_row(i);
      #1;
      tests++; if (bus.host_wr_ready_o !== 1'b1) begin failures++; $display("FAIL load_ready row %0d got %b want 1", i, bus.host_wr_ready_o); end
    end
    @(negedge clk);
    bus.host_wr_valid_i = 1'b0;
  endtask

  task automatic test_read();
    row_t got;
    @(negedge clk);
    bus.rd_addr_i       = 2'd2;
    bus.rd_addr_valid_i = 1'b1;
    @(negedge clk);
    bus.rd_addr_valid_i = 1'b0;
    got = bus.rd_row_o;
    tests++; if (bus.rd_valid_o !== 1'b1) begin failures++; $display("FAIL read_valid got %b want 1", bus.rd_valid_o); end
    tests++; if (bus.rd_addr_o !== 2'd2) begin failures++; $display("FAIL read_addr got %0d want 2", bus.rd_addr_o); end
    tests++; if ($bitstoreal(got[1].re) != 9.0) begin failures++; $display("FAIL read_elem1_re got %f want 9.0", $bitstoreal(got[1].re)); end
    tests++; if ($bitstoreal(got[1].im) != -9.0) begin failures++; $display("FAIL read_elem1_im got %f want -9.0", $bitstoreal(got[1].im)); end
    tests++; if (got !== mdl[2]) begin failures++; $display("FAIL read_row got %h want %h", got, mdl[2]); end
    @(negedge clk);
    tests++; if (bus.rd_valid_o !== 1'b0) begin failures++; $display("FAIL read_valid_drop got %b want 0", bus.rd_valid_o); end
  endtask

  task automatic test_dump_transpose();
    row_t got;
    bus.dump_ready_i = 1'b1;
    @(negedge clk);
    bus.dump_start_i     = 1'b1;
    bus.dump_transpose_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.dump_start_i     = 1'b0;
      bus.dump_transpose_i = 1'b0;
      got = bus.dump_row_o;
      tests++; if (bus.dump_valid_o !== 1'b1) begin failures++; $display("FAIL tr_valid beat %0d got %b want 1", b, bus.dump_valid_o); end
      tests++; if (bus.dump_addr_o !== 2'(b)) begin failures++; $display("FAIL tr_addr got %0d want %0d", bus.dump_addr_o, b); end
      tests++; if (got !== col_of(b)) begin failures++; $display("FAIL tr_row beat %0d got %h want %h", b, got, col_of(b)); end
      tests++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL tr_busy beat %0d got %b want 1", b, bus.busy_o); end
      if (b == 0) begin
        for (int j = 0; j < 4; j++) begin
          tests++; if ($bitstoreal(got[j].re) != real'(4 * j)) begin failures++; $display("FAIL tr_beat0_re elem %0d got %f want %0d", j, $bitstoreal(got[j].re), 4 * j); end
        end
      end
    end
    @(negedge clk);
    tests++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL tr_busy_end got %b want 0", bus.busy_o); end
    tests++; if (bus.dump_valid_o !== 1'b0) begin failures++; $display("FAIL tr_valid_end got %b want 0", bus.dump_valid_o); end
  endtask

  task automatic test_dump_stall();
    int  exp_idx;
    int  cyc;
    logic rdy;
    @(negedge clk);
    bus.dump_start_i     = 1'b1;
    bus.dump_transpose_i = 1'b0;
    @(negedge clk);
    bus.dump_start_i = 1'b0;
    exp_idx = 0;
    cyc     = 0;
    while (exp_idx < 4 && cyc < 20) begin
      tests++; if (bus.dump_valid_o !== 1'b1) begin failures++; $display("FAIL stall_valid cyc %0d got %b want 1", cyc, bus.dump_valid_o); end
      tests++; if (bus.dump_addr_o !== 2'(exp_idx)) begin failures++; $display("FAIL stall_addr cyc %0d got %0d want %0d", cyc, bus.dump_addr_o, exp_idx); end
      tests++; if (bus.dump_row_o !== mdl[exp_idx]) begin failures++; $display("FAIL stall_row cyc %0d got %h want %h", cyc, bus.dump_row_o, mdl[exp_idx]); end
      rdy = ((cyc % 2) == 0);
      bus.dump_ready_i = rdy;
      @(negedge clk);
      if (rdy) exp_idx++;
      cyc++;
    end
    tests++; if (exp_idx != 4) begin failures++; $display("FAIL stall_timeout got %0d beats want 4", exp_idx); end
    tests++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL stall_busy_end got %b want 0", bus.busy_o); end
    bus.dump_ready_i = 1'b1;
  endtask

  task automatic test_flush();
    int cyc;
    bus.dump_ready_i = 1'b1;
    @(negedge clk);
    bus.dump_start_i = 1'b1;
    @(negedge clk);
    bus.dump_start_i = 1'b0;
    tests++; if (bus.dump_addr_o !== 2'd0) begin failures++; $display("FAIL flush_beat0 got %0d want 0", bus.dump_addr_o); end
    @(negedge clk);
    tests++; if (bus.dump_addr_o !== 2'd1) begin failures++; $display("FAIL flush_beat1 got %0d want 1", bus.dump_addr_o); end
    bus.flush_i         = 1'b1;
    bus.rd_addr_i       = 2'd0;
    bus.rd_addr_valid_i = 1'b1;
    @(negedge clk);
    bus.flush_i         = 1'b0;
    bus.rd_addr_valid_i = 1'b0;
    tests++; if (bus.dump_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got %b want 0", bus.dump_valid_o); end
    tests++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL flush_busy got %b want 0", bus.busy_o); end
    tests++; if (bus.rd_valid_o !== 1'b0) begin failures++; $display("FAIL flush_rd_valid got %b want 0", bus.rd_valid_o); end
    bus.dump_start_i = 1'b1;
    @(negedge clk);
    bus.dump_start_i = 1'b0;
    tests++; if (bus.dump_valid_o !== 1'b1) begin failures++; $display("FAIL restart_valid got %b want 1", bus.dump_valid_o); end
    tests++; if (bus.dump_addr_o !== 2'd0) begin failures++; $display("FAIL restart_addr got %0d want 0", bus.dump_addr_o); end
    cyc = 0;
    while (bus.busy_o === 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    tests++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL restart_drain got busy %b want 0", bus.busy_o); end
  endtask

  task automatic test_forward();
    row_t five;
    row_t junk;
    row_t seven;
    five  = const_row(5.0, 0.0);
    junk  = const_row(99.0, 1.0);
    seven = const_row(7.0, -7.0);
    @(negedge clk);
    bus.wr_valid_i      = 1'b1;
    bus.wr_addr_i       = 2'd1;
    bus.wr_row_i        = five;
    bus.rd_addr_i       = 2'd1;
    bus.rd_addr_valid_i = 1'b1;
    bus.host_wr_valid_i = 1'b1;
    bus.host_wr_addr_i  = 2'd1;
    bus.host_wr_row_i   = junk;
    mdl[1]              = five;
    #1;
    tests++; if (bus.host_wr_ready_o !== 1'b0) begin failures++; $display("FAIL fwd_host_block got %b want 0", bus.host_wr_ready_o); end
    @(negedge clk);
    bus.rd_addr_valid_i = 1'b0;
    bus.host_wr_addr_i  = 2'd3;
    bus.host_wr_row_i   = seven;
    mdl[3]              = seven;
    tests++; if (bus.rd_valid_o !== 1'b1) begin failures++; $display("FAIL fwd_valid got %b want 1", bus.rd_valid_o); end
    tests++; if (bus.rd_row_o !== five) begin failures++; $display("FAIL fwd_row got %h want %h", bus.rd_row_o, five); end
    #1;
    tests++; if (bus.host_wr_ready_o !== 1'b1) begin failures++; $display("FAIL fwd_host_other got %b want 1", bus.host_wr_ready_o); end
    @(negedge clk);
    bus.wr_valid_i      = 1'b0;
    bus.host_wr_valid_i = 1'b0;
    bus.rd_addr_i       = 2'd3;
    bus.rd_addr_valid_i = 1'b1;
    @(negedge clk);
    bus.rd_addr_i = 2'd1;
    tests++; if (bus.rd_row_o !== seven) begin failures++; $display("FAIL fwd_host_commit got %h want %h", bus.rd_row_o, seven); end
    @(negedge clk);
    bus.rd_addr_valid_i = 1'b0;
    tests++; if (bus.rd_row_o !== five) begin failures++; $display("FAIL fwd_row1_kept got %h want %h", bus.rd_row_o, five); end
  endtask

  task automatic test_back_to_back_reset();
    @(negedge clk);
    bus.rd_addr_i       = 2'd0;
    bus.rd_addr_valid_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests++; if (bus.rd_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_valid resp %0d got %b want 1", k - 1, bus.rd_valid_o); end
      tests++; if (bus.rd_addr_o !== 2'(k - 1)) begin failures++; $display("FAIL b2b_addr got %0d want %0d", bus.rd_addr_o, k - 1); end
      tests++; if (bus.rd_row_o !== mdl[k-1]) begin failures++; $display("FAIL b2b_row resp %0d got %h want %h", k - 1, bus.rd_row_o, mdl[k-1]); end
      bus.rd_addr_i = (k < 4) ? 2'(k) : 2'd0;
    end
    bus.dump_start_i = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.rd_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_rd_valid got %b want 0", bus.rd_valid_o); end
    tests++; if (bus.rd_row_o !== '0) begin failures++; $display("FAIL midrst_rd_row got %h want 0", bus.rd_row_o); end
    tests++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b want 0", bus.busy_o); end
    tests++; if (bus.dump_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_dump_valid got %b want 0", bus.dump_valid_o); end
    bus.dump_start_i    = 1'b0;
    bus.rd_addr_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rd_addr_i       = 2'd0;
    bus.rd_addr_valid_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests++; if (bus.rd_valid_o !== 1'b1 || bus.rd_row_o !== mdl[k-1]) begin failures++; $display("FAIL postrst_row %0d got valid %b row %h want valid 1 row 0", k - 1, bus.rd_valid_o, bus.rd_row_o); end
      bus.rd_addr_i = 2'(k % 4);
      if (k == 4) bus.rd_addr_valid_i = 1'b0;
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_host_load();
    test_read();
    test_dump_transpose();
    test_dump_stall();
    test_flush();
    test_forward();
    test_back_to_back_reset();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/matrix_row_server.md
# matrix_row_server

Synthesizable row-organised storage for one SIZE×SIZE complex matrix; it is the memory-side responder for the `lu` and `triang_matrix_inv` engines. It answers engine row-read requests with a fixed one-cycle latency and absorbs engine row write-backs. It also gives the host a row-load port and a row-dump stream, with optional transpose so that `lu` L columns come out as rows. It replaces the behavioural row arrays currently held in benches.

## Interface
- SIZE, default 4: matrix dimension, in rows and in elements per row.
- WIDTH, default 64: bits per real or imaginary part, IEEE-754 double.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  aborts an active dump and drops any pending read response.
- rd_addr_i  in  $clog2(SIZE)  engine read row address.
- rd_addr_valid_i  in  1  engine read request.
- rd_row_o  out  SIZE*2*WIDTH  returned row.
- rd_addr_o  out  $clog2(SIZE)  echo of the requested address.
- rd_valid_o  out  1  response valid.
- wr_row_i  in  SIZE*2*WIDTH  engine write-back row.
- wr_addr_i  in  $clog2(SIZE)  engine write address.
- wr_valid_i  in  1  engine write strobe; always accepted.
- host_wr_row_i  in  SIZE*2*WIDTH  host load row.
- host_wr_addr_i  in  $clog2(SIZE)  host load address.
- host_wr_valid_i  in  1  host load request.
- host_wr_ready_o  out  1  host load accepted this cycle.
- dump_start_i  in  1  starts a dump; sampled in IDLE only.
- dump_transpose_i  in  1  captured at start; 1 = emit columns as rows.
- dump_row_o  out  SIZE*2*WIDTH  dump data.
- dump_addr_o  out  $clog2(SIZE)  dump index.
- dump_valid_o  out  1  dump beat valid.
- dump_ready_i  in  1  dump consumer ready.
- busy_o  out  1  high while in DUMP.

## Operation
- Row packing: element j occupies bits [j*2*WIDTH +: 2*WIDTH]. Real part is in the low WIDTH bits, imaginary part in the high WIDTH bits.
- Storage is SIZE registers of SIZE*2*WIDTH bits. All rows clear to 0 on reset.
- Write arbitration:
  - An engine write always wins.
  - host_wr_ready_o = host_wr_valid_i & ~(wr_valid_i & wr_addr_i==host_wr_addr_i). A host write to a different row in the same cycle also commits.
- Read: the request registered at edge N produces rd_valid_o=1, rd_addr_o and rd_row_o during cycle N+1.
  - A same-cycle write to the same row is forwarded (write-first): the response carries the new data.
  - Back-to-back requests give back-to-back responses. There is no stall.
- Dump FSM, states IDLE and DUMP:
  - IDLE→DUMP on dump_start_i. The index clears to 0 and dump_transpose_i is latched.
  - In DUMP, dump_valid_o=1. Plain mode: dump_row_o = mem[idx]. Transpose mode: element j of dump_row_o = element idx of mem[j]. dump_addr_o = idx.
  - Data is combinational from current storage, so writes during a dump are visible immediately.
  - A beat transfers on valid&ready. idx increments. The transfer at idx=SIZE-1 returns the FSM to IDLE; there is no wrap.
  - dump_start_i is ignored while in DUMP.
- flush_i (synchronous, takes priority):
  - DUMP→IDLE; rd_valid_o cleared next cycle.
  - Storage and the write in the same cycle are unaffected.
- No arithmetic is performed. Addresses ≥ SIZE (non-power-of-2 SIZE) are ignored for writes and return 0 for reads.

## Timing
- Reset values: rd_row_o=0, rd_addr_o=0, rd_valid_o=0, host_wr_ready_o=0, dump_valid_o=0, dump_addr_o=0, dump_row_o=0, busy_o=0. FSM resets to IDLE.
- Read latency: exactly 1 cycle, registered outputs.
- Write latency: data is visible to a non-forwarded read request in the next cycle.
- Dump: first beat is valid in the cycle after dump_start_i. SIZE beats complete in SIZE cycles with ready held high.
- Reset asserted mid-dump or mid-read returns all outputs to their reset values immediately.

## Structure
- Shared package `mat_pkg`:
  - row_t typedef (SIZE-element packed complex row).
  - addr_t typedef.
  - Dump state enum.
  - Element-select helper function.
- A single module is expected. An optional sub-module `row_transpose` (combinational column gather) is natural if reused by `triang_matrix_inv` benches.

## Test plan
- Load rows 0..3 via the host with element (i,j) = (i*4+j) + j(-(i*4+j)). Engine-read row 2 → next cycle rd_valid_o=1, rd_addr_o=2, element 1 real = 9.0, imag = -9.0.
- Same-cycle engine write of row 1 = all 5.0+j0 and read of row 1 → the response shows 5.0. A host write to row 1 in that cycle sees host_wr_ready_o=0; a host write to row 3 commits.
- Dump in transpose mode with ready held 1 → 4 beats; beat 0 elements real = 0, 4, 8, 12; busy_o drops after beat 3.
- Dump with dump_ready_i toggled 1,0,1,0 → each beat is held stable while stalled; addresses 0..3 in order with no skip or repeat.
- flush_i at dump beat 1 → dump_valid_o=0 next cycle, FSM in IDLE; a new dump_start_i restarts at addr 0.
- Read requests to rows 0,1,2,3 on consecutive cycles, then reset pulsed mid-stream → responses 0..3 before the reset; after reset, rd_valid_o=0 and all rows read 0.
